// File: rtl/bus_decoder.sv
// bus_decoder: base/mask address decoder between the CPU data master and SLAVES memory-mapped
// slaves, with wait aggregation, registered read return, unmapped/timeout error response and a
// sticky error-capture register. Stall-timeout watchdog enabled by defining BUS_DECODER_TIMEOUT_EN.
module bus_decoder #(
  parameter int                              SLAVES     = 12,
  parameter int                              ADDR_W     = 32,
  parameter int                              DATA_W     = 32,
  parameter logic [SLAVES-1:0][ADDR_W-1:0]   BASE       = '0,
  parameter logic [SLAVES-1:0][ADDR_W-1:0]   MASK       = '0,
  parameter int                              TIMEOUT    = 255,
  parameter logic [DATA_W-1:0]               ERROR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     read,
  input  logic                     write,
  output logic                     waitRequest,
  output logic [DATA_W-1:0]        readData,
  output logic                     readDataValid,
  output logic [SLAVES-1:0]        slaveChipEnable,
  output logic [SLAVES-1:0]        slaveRead,
  output logic [SLAVES-1:0]        slaveWrite,
  output logic [ADDR_W-3:0]        slaveAddress,
  input  logic [SLAVES-1:0]        slaveWaitRequest,
  input  logic [SLAVES*DATA_W-1:0] slaveReadData,
  output logic                     busError,
  output logic                     errorValid,
  output logic                     errorCause,
  output logic [ADDR_W-1:0]        errorAddress,
  input  logic                     errorClear
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ABORT
  } state_e;

  state_e              state_q, state_d;

`ifdef BUS_DECODER_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0]    waitCount_q, waitCount_d;
`else
  localparam int unusedTimeout = TIMEOUT;
`endif

  logic [SLAVES-1:0]   chipEnable;
  logic                selWait;
  logic [DATA_W-1:0]   selData;
  logic [ADDR_W-1:0]   selMask;
  logic [ADDR_W-1:0]   maskedAddr;
  logic                unusedAddrBits;
  logic                req;
  logic                mapped;
  logic                inAbort;
  logic                complete;
  logic                errEvent;
  logic [DATA_W-1:0]   retData;

  logic [DATA_W-1:0]   readData_q;
  logic                readDataValid_q;
  logic                busError_q;
  logic                errorValid_q, errorValid_d;
  logic                errorCause_q, errorCause_d;
  logic [ADDR_W-1:0]   errorAddress_q, errorAddress_d;

  // Walk from the top index down so the lowest-indexed hit overwrites any higher one.
  always_comb begin
    chipEnable = '0;
    selWait    = 1'b0;
    selData    = '0;
    selMask    = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if ((address & ~MASK[i]) == BASE[i]) begin
        chipEnable    = '0;
        chipEnable[i] = 1'b1;
        selWait       = slaveWaitRequest[i];
        selData       = slaveReadData[i*DATA_W +: DATA_W];
        selMask       = MASK[i];
      end
    end
  end

  assign req             = read | write;
  assign mapped          = |chipEnable;
  assign inAbort         = (state_q == ST_ABORT);
  assign maskedAddr      = address & selMask;
  assign slaveAddress    = maskedAddr[ADDR_W-1:2];
  assign unusedAddrBits  = ^maskedAddr[1:0];
  assign slaveChipEnable = chipEnable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
`ifdef BUS_DECODER_TIMEOUT_EN
      waitCount_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef BUS_DECODER_TIMEOUT_EN
      waitCount_q <= waitCount_d;
`endif
    end
  end

  // A master that drops its request mid-stall simply returns the FSM to IDLE with no completion.
  always_comb begin
    state_d = state_q;
`ifdef BUS_DECODER_TIMEOUT_EN
    waitCount_d = waitCount_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (waitRequest) begin
          state_d = ST_WAIT;
`ifdef BUS_DECODER_TIMEOUT_EN
          waitCount_d = CNT_W'(1);
`endif
        end
      end
      ST_WAIT: begin
        if (!waitRequest) begin
          state_d = ST_IDLE;
`ifdef BUS_DECODER_TIMEOUT_EN
          waitCount_d = '0;
        end else if (waitCount_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = ST_ABORT;
          waitCount_d = '0;
        end else begin
          waitCount_d = waitCount_q + CNT_W'(1);
`endif
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    waitRequest = req & mapped & selWait & ~inAbort;
    slaveRead   = inAbort ? '0 : (chipEnable & {SLAVES{read}});
    slaveWrite  = inAbort ? '0 : (chipEnable & {SLAVES{write}});
    complete    = req & ~waitRequest;
    errEvent    = (complete & ~mapped) | inAbort;
    retData     = (mapped & ~inAbort) ? selData : ERROR_DATA;
  end

  // A new error wins over a coincident clear, so it is never lost.
  always_comb begin
    errorValid_d   = errorValid_q;
    errorCause_d   = errorCause_q;
    errorAddress_d = errorAddress_q;
    if (errorClear) begin
      errorValid_d = 1'b0;
    end
    if (errEvent && (!errorValid_q || errorClear)) begin
      errorValid_d   = 1'b1;
      errorCause_d   = inAbort;
      errorAddress_d = address;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readData_q      <= '0;
      readDataValid_q <= 1'b0;
      busError_q      <= 1'b0;
      errorValid_q    <= 1'b0;
      errorCause_q    <= 1'b0;
      errorAddress_q  <= '0;
    end else begin
      readDataValid_q <= complete & read;
      if (complete && read) begin
        readData_q <= retData;
      end
      busError_q     <= errEvent;
      errorValid_q   <= errorValid_d;
      errorCause_q   <= errorCause_d;
      errorAddress_q <= errorAddress_d;
    end
  end

  assign readData      = readData_q;
  assign readDataValid = readDataValid_q;
  assign busError      = busError_q;
  assign errorValid    = errorValid_q;
  assign errorCause    = errorCause_q;
  assign errorAddress  = errorAddress_q;

endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: table-driven zero-wait vectors plus hand-written stall, error-capture,
// timeout (when BUS_DECODER_TIMEOUT_EN is defined) and reset-in-WAIT sequences.
module tb_bus_decoder;

  localparam int SLAVES = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [SLAVES-1:0][ADDR_W-1:0] BASE_P = {32'h01000000, 32'h00004010, 32'h00000000};
  localparam logic [SLAVES-1:0][ADDR_W-1:0] MASK_P = {32'h007FFFFF, 32'h0000000F, 32'h00003FFF};

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [ADDR_W-1:0]        address = '0;
  logic                     read = 1'b0;
  logic                     write = 1'b0;
  logic                     waitRequest;
  logic [DATA_W-1:0]        readData;
  logic                     readDataValid;
  logic [SLAVES-1:0]        slaveChipEnable;
  logic [SLAVES-1:0]        slaveRead;
  logic [SLAVES-1:0]        slaveWrite;
  logic [ADDR_W-3:0]        slaveAddress;
  logic [SLAVES-1:0]        slaveWaitRequest = '0;
  logic [SLAVES*DATA_W-1:0] slaveReadData = {32'h22222222, 32'hA5A5A5A5, 32'h11111111};
  logic                     busError;
  logic                     errorValid;
  logic                     errorCause;
  logic [ADDR_W-1:0]        errorAddress;
  logic                     errorClear = 1'b0;

  int checks = 0;
  int errors = 0;

  bus_decoder #(
    .SLAVES(SLAVES), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BASE(BASE_P), .MASK(MASK_P), .TIMEOUT(8), .ERROR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .waitRequest(waitRequest), .readData(readData), .readDataValid(readDataValid),
    .slaveChipEnable(slaveChipEnable), .slaveRead(slaveRead), .slaveWrite(slaveWrite),
    .slaveAddress(slaveAddress), .slaveWaitRequest(slaveWaitRequest),
    .slaveReadData(slaveReadData), .busError(busError), .errorValid(errorValid),
    .errorCause(errorCause), .errorAddress(errorAddress), .errorClear(errorClear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [2:0]  sw;
    logic [2:0]  ce;
    logic [2:0]  rs;
    logic [2:0]  ws;
    logic [29:0] sa;
    logic        wreq;
    logic        rdv;
    logic [31:0] rdata;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    address = v.addr;
    read = v.rd;
    write = v.wr;
    slaveWaitRequest = v.sw;
    #1;
    checkOutput("vecChipEnable", slaveChipEnable, v.ce);
    checkOutput("vecSlaveRead", slaveRead, v.rs);
    checkOutput("vecSlaveWrite", slaveWrite, v.ws);
    checkOutput("vecSlaveAddress", slaveAddress, v.sa);
    checkOutput("vecWaitRequest", waitRequest, v.wreq);
    tick();
    checkOutput("vecReadDataValid", readDataValid, v.rdv);
    checkOutput("vecReadData", readData, v.rdata);
    checkOutput("vecBusError", busError, 1'b0);
  endtask

  task automatic stalledAccess(input logic [31:0] addr, input logic rd, input logic wr,
                               input int nWait, input logic [2:0] selOneHot,
                               input logic [29:0] expSa, input logic [31:0] expData);
    int highCount = 0;
    address = addr;
    read = rd;
    write = wr;
    for (int k = 0; k <= nWait; k++) begin
      slaveWaitRequest = (k < nWait) ? selOneHot : 3'b000;
      #1;
      if (waitRequest) highCount++;
      checkOutput("stallStrobe", rd ? slaveRead : slaveWrite, selOneHot);
      checkOutput("stallSlaveAddress", slaveAddress, expSa);
      tick();
      if (k < nWait) checkOutput("stallNoRdv", readDataValid, 1'b0);
    end
    read = 1'b0;
    write = 1'b0;
    slaveWaitRequest = '0;
    checkOutput("stallHighCycles", highCount, nWait);
    checkOutput("stallRdv", readDataValid, rd);
    if (rd) checkOutput("stallReadData", readData, expData);
    checkOutput("stallBusError", busError, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    logic [31:0] firstErrAddr;
    logic        firstErrCause;
    int          high;
    int          guard;

    vecs[0] = '{32'h00004018, 1'b1, 1'b0, 3'b000, 3'b010, 3'b010, 3'b000, 30'd2,        1'b0, 1'b1, 32'hA5A5A5A5};
    vecs[1] = '{32'h00000100, 1'b0, 1'b1, 3'b000, 3'b001, 3'b000, 3'b001, 30'h40,       1'b0, 1'b0, 32'hA5A5A5A5};
    vecs[2] = '{32'h00003FFC, 1'b1, 1'b0, 3'b000, 3'b001, 3'b001, 3'b000, 30'hFFF,      1'b0, 1'b1, 32'h11111111};
    vecs[3] = '{32'h017FFFFC, 1'b1, 1'b0, 3'b000, 3'b100, 3'b100, 3'b000, 30'h1FFFFF,   1'b0, 1'b1, 32'h22222222};
    vecs[4] = '{32'h00004018, 1'b0, 1'b0, 3'b111, 3'b010, 3'b000, 3'b000, 30'd2,        1'b0, 1'b0, 32'h22222222};
    vecs[5] = '{32'h00004018, 1'b1, 1'b0, 3'b101, 3'b010, 3'b010, 3'b000, 30'd2,        1'b0, 1'b1, 32'hA5A5A5A5};
    vecs[6] = '{32'h01000004, 1'b0, 1'b1, 3'b011, 3'b100, 3'b000, 3'b100, 30'd1,        1'b0, 1'b0, 32'hA5A5A5A5};
    vecs[7] = '{32'h00004010, 1'b1, 1'b0, 3'b000, 3'b010, 3'b010, 3'b000, 30'd0,        1'b0, 1'b1, 32'hA5A5A5A5};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstWaitRequest", waitRequest, 1'b0);
    checkOutput("rstReadData", readData, 32'h0);
    checkOutput("rstReadDataValid", readDataValid, 1'b0);
    checkOutput("rstBusError", busError, 1'b0);
    checkOutput("rstErrorValid", errorValid, 1'b0);
    checkOutput("rstErrorCause", errorCause, 1'b0);
    checkOutput("rstErrorAddress", errorAddress, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Stalled write to slave 2 (3 wait cycles) and stalled read from slave 1 (2 wait cycles)
    stalledAccess(32'h01000010, 1'b0, 1'b1, 3, 3'b100, 30'd4, 32'h0);
    stalledAccess(32'h00004014, 1'b1, 1'b0, 2, 3'b010, 30'd1, 32'hA5A5A5A5);

    // Unmapped read
    checkOutput("preUnmappedErrorValid", errorValid, 1'b0);
    address = 32'h00005000;
    read = 1'b1;
    #1;
    checkOutput("unmapChipEnable", slaveChipEnable, 3'b000);
    checkOutput("unmapSlaveRead", slaveRead, 3'b000);
    checkOutput("unmapWaitRequest", waitRequest, 1'b0);
    tick();
    read = 1'b0;
    checkOutput("unmapReadDataValid", readDataValid, 1'b1);
    checkOutput("unmapReadData", readData, 32'hDEADBEEF);
    checkOutput("unmapBusError", busError, 1'b1);
    checkOutput("unmapErrorValid", errorValid, 1'b1);
    checkOutput("unmapErrorCause", errorCause, 1'b0);
    checkOutput("unmapErrorAddress", errorAddress, 32'h00005000);
    tick();
    checkOutput("unmapBusErrorPulse", busError, 1'b0);

`ifdef BUS_DECODER_TIMEOUT_EN
    errorClear = 1'b1;
    tick();
    errorClear = 1'b0;
    checkOutput("clearErrorValid", errorValid, 1'b0);
    address = 32'h01000020;
    read = 1'b1;
    slaveWaitRequest = 3'b100;
    high = 0;
    guard = 0;
    #1;
    while (waitRequest && guard < 20) begin
      high++;
      guard++;
      tick();
    end
    checkOutput("toHighCycles", high, 8);
    checkOutput("toAbortSlaveRead", slaveRead, 3'b000);
    checkOutput("toAbortSlaveWrite", slaveWrite, 3'b000);
    tick();
    read = 1'b0;
    slaveWaitRequest = '0;
    checkOutput("toBusError", busError, 1'b1);
    checkOutput("toReadDataValid", readDataValid, 1'b1);
    checkOutput("toReadData", readData, 32'hDEADBEEF);
    checkOutput("toErrorValid", errorValid, 1'b1);
    checkOutput("toErrorCause", errorCause, 1'b1);
    checkOutput("toErrorAddress", errorAddress, 32'h01000020);
    firstErrAddr = 32'h01000020;
    firstErrCause = 1'b1;
`else
    address = 32'h01000020;
    read = 1'b1;
    slaveWaitRequest = 3'b100;
    high = 0;
    guard = 0;
    #1;
    while (waitRequest && guard < 20) begin
      high++;
      guard++;
      tick();
    end
    checkOutput("longStallHighCycles", high, 20);
    slaveWaitRequest = '0;
    #1;
    checkOutput("longStallRelease", waitRequest, 1'b0);
    tick();
    read = 1'b0;
    checkOutput("longStallReadDataValid", readDataValid, 1'b1);
    checkOutput("longStallReadData", readData, 32'h22222222);
    checkOutput("longStallBusError", busError, 1'b0);
    checkOutput("longStallErrorCause", errorCause, 1'b0);
    firstErrAddr = 32'h00005000;
    firstErrCause = 1'b0;
`endif

    // Second error before clear leaves the first capture intact
    address = 32'h00006000;
    write = 1'b1;
    tick();
    write = 1'b0;
    checkOutput("secondBusError", busError, 1'b1);
    checkOutput("secondReadDataValid", readDataValid, 1'b0);
    checkOutput("secondErrorValid", errorValid, 1'b1);
    checkOutput("secondErrorAddress", errorAddress, firstErrAddr);
    checkOutput("secondErrorCause", errorCause, firstErrCause);

    // Clear coincident with a new unmapped error
    address = 32'h00007000;
    read = 1'b1;
    errorClear = 1'b1;
    tick();
    read = 1'b0;
    checkOutput("clrNewErrorValid", errorValid, 1'b1);
    checkOutput("clrNewErrorAddress", errorAddress, 32'h00007000);
    checkOutput("clrNewErrorCause", errorCause, 1'b0);
    checkOutput("clrNewBusError", busError, 1'b1);
    tick();
    errorClear = 1'b0;
    checkOutput("clrOnlyErrorValid", errorValid, 1'b0);
    checkOutput("clrOnlyBusError", busError, 1'b0);

    // Master drops its request mid-stall: no completion, FSM back in IDLE
    address = 32'h01000008;
    read = 1'b1;
    slaveWaitRequest = 3'b100;
    #1;
    checkOutput("dropWaitRequest", waitRequest, 1'b1);
    tick();
    read = 1'b0;
    #1;
    checkOutput("dropWaitRequestLow", waitRequest, 1'b0);
    tick();
    slaveWaitRequest = '0;
    checkOutput("dropReadDataValid", readDataValid, 1'b0);
    checkOutput("dropBusError", busError, 1'b0);
    checkOutput("dropErrorValid", errorValid, 1'b0);
    address = 32'h00004018;
    read = 1'b1;
    tick();
    read = 1'b0;
    checkOutput("afterDropReadDataValid", readDataValid, 1'b1);
    checkOutput("afterDropReadData", readData, 32'hA5A5A5A5);

    // Reset asserted during WAIT
    address = 32'h00009000;
    read = 1'b1;
    tick();
    checkOutput("preRstErrorValid", errorValid, 1'b1);
    checkOutput("preRstReadData", readData, 32'hDEADBEEF);
    address = 32'h01000000;
    slaveWaitRequest = 3'b100;
    tick();
    checkOutput("preRstInWait", waitRequest, 1'b1);
    reset = 1'b1;
    read = 1'b0;
    slaveWaitRequest = '0;
    tick();
    checkOutput("midRstWaitRequest", waitRequest, 1'b0);
    checkOutput("midRstReadDataValid", readDataValid, 1'b0);
    checkOutput("midRstReadData", readData, 32'h0);
    checkOutput("midRstBusError", busError, 1'b0);
    checkOutput("midRstErrorValid", errorValid, 1'b0);
    checkOutput("midRstErrorCause", errorCause, 1'b0);
    checkOutput("midRstErrorAddress", errorAddress, 32'h0);
    checkOutput("midRstSlaveRead", slaveRead, 3'b000);
    reset = 1'b0;
    address = 32'h00004018;
    read = 1'b1;
    #1;
    checkOutput("postRstWaitRequest", waitRequest, 1'b0);
    checkOutput("postRstSlaveRead", slaveRead, 3'b010);
    tick();
    read = 1'b0;
    checkOutput("postRstReadDataValid", readDataValid, 1'b1);
    checkOutput("postRstReadData", readData, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
